adc_frame_aligner: RTL and testbench

Parametrised deserialized-ADC front end for LTC2195-class serial-LVDS converters. Sits in the divided (frame-rate) clock domain directly after the per-lane ISERDES blocks. Aligns all lanes to the FR frame word by issuing bitslip pulses, then reassembles the interleaved lane bits into N parallel samples. Also provides a built-in test-pattern checker for link qualification.

---
 rtl/adc_if_pkg.sv | 15 +
 rtl/adc_lane_interleave.sv | 17 +
 rtl/adc_frame_aligner.sv | 172 +++++++++++++++++
 tb/tb_adc_frame_aligner.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_if_pkg.sv
// rtl/adc_if_pkg.sv - alignment FSM states and default link constants for the ADC front end
package adc_if_pkg;

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_SLIP_WAIT,
    ST_LOCKED
  } align_state_t;

  localparam logic [7:0]  FRAME_PAT_DEF = 8'hF0;
  localparam logic [15:0] TP_DEF        = 16'hB2E9;

endpackage

// File: rtl/adc_lane_interleave.sv
// rtl/adc_lane_interleave.sv - combinational remap of LANES deserialized lane words into one sample
module adc_lane_interleave #(
  parameter int LANES = 2,
  parameter int SER   = 8
)(
  input  logic [LANES*SER-1:0] i_lanes,
  output logic [LANES*SER-1:0] o_sample
);

  // Lane l carries every LANES-th sample bit starting at the MSB minus l.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar k = 0; k < SER; k++) begin : g_bit
      assign o_sample[LANES*SER-1-l-k*LANES] = i_lanes[l*SER+SER-1-k];
    end
  end

endmodule

// File: rtl/adc_frame_aligner.sv
// rtl/adc_frame_aligner.sv - bitslip frame alignment, lane reassembly and test-pattern checker
module adc_frame_aligner
  import adc_if_pkg::*;
#(
  parameter int                   N_CH      = 2,
  parameter int                   LANES     = 2,
  parameter int                   SER       = 8,
  parameter logic [SER-1:0]       FRAME_PAT = FRAME_PAT_DEF,
  parameter logic [LANES*SER-1:0] TP        = TP_DEF,
  parameter int                   SETTLE    = 16,
  parameter int                   BS_WAIT   = 4,
  parameter int                   MISS_MAX  = 3
)(
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          realign_in,
  input  logic                          tp_mode_in,
  input  logic                          tp_clr_in,
  input  logic [SER-1:0]                fr_in,
  input  logic [N_CH*LANES*SER-1:0]     d_in,
  output logic                          bitslip_out,
  output logic                          locked_out,
  output logic                          align_err_out,
  output logic [$clog2(SER)-1:0]        slip_cnt_out,
  output logic [N_CH*LANES*SER-1:0]     adc_out,
  output logic                          adc_valid_out,
  output logic [15:0]                   tp_err_cnt_out
);

  localparam int SAMPLE_W = LANES * SER;
  localparam int SW       = $clog2(SER);
  localparam int CW       = $clog2((SETTLE > BS_WAIT) ? SETTLE : BS_WAIT) + 1;
  localparam int MW       = $clog2(MISS_MAX) + 1;
  localparam int NW       = $clog2(N_CH + 1);

  align_state_t              r_state, w_state_nxt;
  logic [CW-1:0]             r_cnt, w_cnt_nxt;
  logic [MW-1:0]             r_miss, w_miss_nxt;
  logic [SW-1:0]             r_slip_cnt, w_slip_cnt_nxt;
  logic                      r_align_err, w_align_err_nxt;
  logic                      w_fr_match;
  logic [N_CH*SAMPLE_W-1:0]  w_sample;
  logic [N_CH*SAMPLE_W-1:0]  r_adc;
  logic                      r_adc_valid;
  logic [NW-1:0]             w_tp_miss;
  logic [16:0]               w_tp_sum;
  logic [15:0]               r_tp_cnt;

  assign w_fr_match = (fr_in == FRAME_PAT);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= ST_SETTLE;
      r_cnt       <= '0;
      r_miss      <= '0;
      r_slip_cnt  <= '0;
      r_align_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_miss      <= w_miss_nxt;
      r_slip_cnt  <= w_slip_cnt_nxt;
      r_align_err <= w_align_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_miss_nxt      = r_miss;
    w_slip_cnt_nxt  = r_slip_cnt;
    w_align_err_nxt = r_align_err;
    case (r_state)
      ST_SETTLE: begin
        if (r_cnt == CW'(SETTLE - 1)) begin
          w_state_nxt = ST_CHECK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_CHECK: begin
        if (w_fr_match) begin
          w_state_nxt = ST_LOCKED;
          w_miss_nxt  = '0;
        end else begin
          w_state_nxt    = ST_SLIP;
          w_slip_cnt_nxt = (r_slip_cnt == SW'(SER - 1)) ? '0 : r_slip_cnt + 1'b1;
        end
      end
      ST_SLIP: begin
        w_state_nxt = ST_SLIP_WAIT;
        w_cnt_nxt   = '0;
      end
      ST_SLIP_WAIT: begin
        // A wrapped slip counter means every bit phase has been tried once.
        if (r_slip_cnt == '0) w_align_err_nxt = 1'b1;
        if (r_cnt == CW'(BS_WAIT - 1)) begin
          w_state_nxt = ST_CHECK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (w_fr_match) begin
          w_miss_nxt = '0;
        end else if (r_miss == MW'(MISS_MAX - 1)) begin
          w_state_nxt = ST_CHECK;
          w_miss_nxt  = '0;
        end else begin
          w_miss_nxt = r_miss + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_SETTLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if (realign_in) begin
      w_state_nxt     = ST_SETTLE;
      w_cnt_nxt       = '0;
      w_miss_nxt      = '0;
      w_slip_cnt_nxt  = '0;
      w_align_err_nxt = 1'b0;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    adc_lane_interleave #(
      .LANES (LANES),
      .SER   (SER)
    ) u_interleave (
      .i_lanes  (d_in[c*SAMPLE_W +: SAMPLE_W]),
      .o_sample (w_sample[c*SAMPLE_W +: SAMPLE_W])
    );
  end

  always_comb begin
    w_tp_miss = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (r_adc[c*SAMPLE_W +: SAMPLE_W] != TP) w_tp_miss = w_tp_miss + NW'(1);
    end
  end

  assign w_tp_sum = {1'b0, r_tp_cnt} + 17'(w_tp_miss);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_adc       <= '0;
      r_adc_valid <= 1'b0;
      r_tp_cnt    <= '0;
    end else begin
      r_adc       <= w_sample;
      r_adc_valid <= (r_state == ST_LOCKED);
      if (tp_clr_in) begin
        r_tp_cnt <= '0;
      end else if (tp_mode_in && r_adc_valid) begin
        r_tp_cnt <= w_tp_sum[16] ? 16'hFFFF : w_tp_sum[15:0];
      end
    end
  end

  assign bitslip_out    = (r_state == ST_SLIP);
  assign locked_out     = (r_state == ST_LOCKED);
  assign align_err_out  = r_align_err;
  assign slip_cnt_out   = r_slip_cnt;
  assign adc_out        = r_adc;
  assign adc_valid_out  = r_adc_valid;
  assign tp_err_cnt_out = r_tp_cnt;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// tb/tb_adc_frame_aligner.sv - scoreboard bench with a rotating ISERDES model for adc_frame_aligner
module tb_adc_frame_aligner;

  localparam int N_CH     = 2;
  localparam int LANES    = 2;
  localparam int SER      = 8;
  localparam int SETTLE   = 16;
  localparam int BS_WAIT  = 4;
  localparam int MISS_MAX = 3;
  localparam logic [7:0] FRAME = 8'hF0;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        realign_in = 1'b0;
  logic        tp_mode_in = 1'b0;
  logic        tp_clr_in = 1'b0;
  logic [7:0]  fr_in;
  logic [31:0] d_in;
  logic        bitslip_out;
  logic        locked_out;
  logic        align_err_out;
  logic [2:0]  slip_cnt_out;
  logic [31:0] adc_out;
  logic        adc_valid_out;
  logic [15:0] tp_err_cnt_out;

  adc_frame_aligner #(
    .N_CH(N_CH), .LANES(LANES), .SER(SER), .FRAME_PAT(FRAME), .TP(16'hB2E9),
    .SETTLE(SETTLE), .BS_WAIT(BS_WAIT), .MISS_MAX(MISS_MAX)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .realign_in(realign_in),
    .tp_mode_in(tp_mode_in), .tp_clr_in(tp_clr_in), .fr_in(fr_in), .d_in(d_in),
    .bitslip_out(bitslip_out), .locked_out(locked_out), .align_err_out(align_err_out),
    .slip_cnt_out(slip_cnt_out), .adc_out(adc_out), .adc_valid_out(adc_valid_out),
    .tp_err_cnt_out(tp_err_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_slips = 0;
  int off_base = 0;
  int off;
  int slip_cyc [$];
  logic [31:0] exp_q [$];
  logic       fr_force = 1'b0;
  logic [7:0] fr_force_val = 8'h00;
  logic [7:0] lane_w [4];

  // Hand-computed vectors: lane A/B words and the interleaved sample they form.
  logic [7:0]  TA [5] = '{8'hDE, 8'hFF, 8'h00, 8'hF0, 8'h00};
  logic [7:0]  TB [5] = '{8'h49, 8'h00, 8'hFF, 8'h0F, 8'h00};
  logic [15:0] TE [5] = '{16'hB2E9, 16'hAAAA, 16'h5555, 16'hAA55, 16'h0000};

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // ISERDES model: words are rotated by the current bit offset; each bitslip removes one bit.
  always_comb begin
    off = ((off_base - n_slips) % SER + SER) % SER;
    fr_in = fr_force ? fr_force_val : rotl(FRAME, off);
    d_in = '0;
    for (int i = 0; i < 4; i++) d_in[i*8 +: 8] = rotl(lane_w[i], off);
  end

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (bitslip_out) begin
      n_slips++;
      slip_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_in && adc_valid_out && exp_q.size() > 0) check("sb_sample", adc_out, exp_q.pop_front());
  end

  task automatic stream();
    logic [31:0] prev;
    prev = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in); #1;
      if (i > 0) exp_q.push_back(prev);
      lane_w[0] = TA[i];
      lane_w[1] = TB[i];
      lane_w[2] = TA[(i+1)%5];
      lane_w[3] = TB[(i+1)%5];
      prev = {TE[(i+1)%5], TE[i]};
    end
    @(posedge clk_in); #1;
    exp_q.push_back(prev);
    repeat (3) @(posedge clk_in);
    #1;
    check("sb_drained", exp_q.size(), 0);
  endtask

  task automatic wait_lock(input string name, input int budget);
    int n;
    n = 0;
    while (!locked_out && n < budget) begin
      @(posedge clk_in); #1;
      n++;
    end
    check(name, locked_out, 1);
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0, q0;
    for (int i = 0; i < 4; i++) lane_w[i] = 8'h00;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_bitslip", bitslip_out, 0);
    check("rst_locked", locked_out, 0);
    check("rst_align_err", align_err_out, 0);
    check("rst_slip_cnt", slip_cnt_out, 0);
    check("rst_adc", adc_out, 0);
    check("rst_valid", adc_valid_out, 0);
    check("rst_tp_cnt", tp_err_cnt_out, 0);

    // 1: aligned from reset
    lane_w[0] = TA[0]; lane_w[1] = TB[0]; lane_w[2] = TA[1]; lane_w[3] = TB[1];
    s0 = n_slips;
    @(negedge clk_in); rst_in = 1'b1;
    n = 0;
    while (!locked_out && n < 100) begin
      @(posedge clk_in); #1;
      n++;
    end
    check("t1_lock_latency", n, SETTLE + 1);
    check("t1_no_slips", n_slips - s0, 0);
    @(posedge clk_in); #1;
    check("t1_valid", adc_valid_out, 1);
    check("t1_ch0", adc_out[15:0], 16'hB2E9);
    stream();

    // 2: three bits off after reset
    @(negedge clk_in); rst_in = 1'b0;
    off_base = n_slips + 3;
    s0 = n_slips;
    q0 = slip_cyc.size();
    @(negedge clk_in); rst_in = 1'b1;
    wait_lock("t2_lock", 300);
    check("t2_slips", n_slips - s0, 3);
    check("t2_slip_cnt", slip_cnt_out, 3);
    if (slip_cyc.size() == q0 + 3) begin
      check("t2_gap1", slip_cyc[q0+1] - slip_cyc[q0], BS_WAIT + 2);
      check("t2_gap2", slip_cyc[q0+2] - slip_cyc[q0+1], BS_WAIT + 2);
    end
    stream();

    // 3: short bursts keep lock, a MISS_MAX burst drops it
    @(posedge clk_in); #1;
    fr_force_val = 8'h00;
    fr_force = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 fr_force = 1'b0;
    check("t3_burst_a_locked", locked_out, 1);
    @(posedge clk_in); #1;
    fr_force = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 fr_force = 1'b0;
    check("t3_burst_b_locked", locked_out, 1);
    @(posedge clk_in); #1;
    off_base = n_slips + 1;
    repeat (2) @(posedge clk_in);
    #1;
    check("t3_two_miss_locked", locked_out, 1);
    @(posedge clk_in); #1;
    check("t3_unlock", locked_out, 0);
    @(posedge clk_in); #1;
    check("t3_slip_resumes", bitslip_out, 1);
    check("t3_slip_cnt", slip_cnt_out, 4);
    wait_lock("t3_relock", 100);
    stream();

    // 4: frame never matches
    fr_force_val = 8'h00;
    fr_force = 1'b1;
    @(posedge clk_in); #1 realign_in = 1'b1;
    @(posedge clk_in); #1 realign_in = 1'b0;
    check("t4_realign_locked", locked_out, 0);
    check("t4_realign_cnt", slip_cnt_out, 0);
    s0 = n_slips;
    n = 0;
    while (!align_err_out && n < 400) begin
      @(posedge clk_in); #1;
      n++;
    end
    check("t4_align_err", align_err_out, 1);
    check("t4_slips_at_err", n_slips - s0, 8);
    check("t4_not_locked", locked_out, 0);
    repeat (20) @(posedge clk_in);
    #1;
    check("t4_still_slipping", (n_slips - s0) > 8, 1);
    check("t4_err_sticky", align_err_out, 1);
    realign_in = 1'b1;
    @(posedge clk_in); #1 realign_in = 1'b0;
    check("t4_err_cleared", align_err_out, 0);

    // 6: reset during a slip pulse
    n = 0;
    while (!bitslip_out && n < 200) begin
      @(posedge clk_in); #1;
      n++;
    end
    check("t6_in_slip", bitslip_out, 1);
    rst_in = 1'b0;
    #1;
    check("t6_bitslip", bitslip_out, 0);
    check("t6_locked", locked_out, 0);
    check("t6_slip_cnt", slip_cnt_out, 0);
    check("t6_adc", adc_out, 0);
    check("t6_valid", adc_valid_out, 0);
    fr_force = 1'b0;
    @(negedge clk_in); rst_in = 1'b1;
    wait_lock("t6_relock", 300);
    stream();

    // 5: test-pattern checker
    lane_w[0] = 8'hDE; lane_w[1] = 8'h49; lane_w[2] = 8'h00; lane_w[3] = 8'h00;
    repeat (3) @(posedge clk_in);
    #1;
    check("t5_valid", adc_valid_out, 1);
    check("t5_start", tp_err_cnt_out, 0);
    tp_mode_in = 1'b1;
    repeat (10) @(posedge clk_in);
    #1 tp_mode_in = 1'b0;
    check("t5_count10", tp_err_cnt_out, 10);
    tp_clr_in = 1'b1;
    @(posedge clk_in); #1 tp_clr_in = 1'b0;
    check("t5_clear", tp_err_cnt_out, 0);
    tp_mode_in = 1'b1;
    tp_clr_in = 1'b1;
    @(posedge clk_in); #1;
    tp_mode_in = 1'b0;
    tp_clr_in = 1'b0;
    check("t5_clr_wins", tp_err_cnt_out, 0);
    lane_w[0] = 8'h00; lane_w[1] = 8'h00;
    repeat (3) @(posedge clk_in);
    #1;
    tp_mode_in = 1'b1;
    repeat (32767) @(posedge clk_in);
    #1;
    check("t5_fffe", tp_err_cnt_out, 16'hFFFE);
    @(posedge clk_in); #1;
    check("t5_sat_pair", tp_err_cnt_out, 16'hFFFF);
    repeat (3) @(posedge clk_in);
    #1;
    check("t5_sat_hold", tp_err_cnt_out, 16'hFFFF);
    tp_mode_in = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
